// File: rtl/tdm_demux.sv
// Receive-side demultiplexer for a select-multiplexed TDM link: frame_sync locks the slot counter.
// Optional macro TDM_FRAME_LATCH_EN publishes whole frames atomically from shadow registers.
module tdm_demux #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 4,
   parameter int SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   input  logic                     frame_sync,
   output logic [N_CH*DATA_W-1:0]   ch_data,
   output logic [N_CH-1:0]          ch_strobe,
   output logic [SEL_W-1:0]         slot,
   output logic                     locked,
   output logic                     frame_done,
   output logic                     sync_err
);

   localparam logic [0:0]       HUNT      = 1'b0;
   localparam logic [0:0]       RUN       = 1'b1;
   localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);
   localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

   logic [0:0]              r_state;
   logic [SEL_W-1:0]        r_slot;
   logic [N_CH*DATA_W-1:0]  r_ch_data;
   logic [N_CH-1:0]         r_ch_strobe;
   logic                    r_frame_done;
   logic                    r_sync_err;

   logic                    w_accept;
   logic [N_CH-1:0]         w_wr_sel;
   logic [SEL_W-1:0]        w_slot_nxt;
   logic [0:0]              w_state_nxt;
   logic                    w_frame_done_nxt;
   logic                    w_sync_err_nxt;

   assign w_accept = en & din_valid;

   // NOTE: every signal gets a default before the branches so no latch is inferred.
   always_comb begin
      w_wr_sel         = '0;
      w_slot_nxt       = r_slot;
      w_state_nxt      = r_state;
      w_frame_done_nxt = 1'b0;
      w_sync_err_nxt   = 1'b0;
      if (w_accept) begin
         if (r_state == HUNT) begin
            if (frame_sync) begin
               w_wr_sel[0] = 1'b1;
               w_slot_nxt  = SLOT_ONE;
               w_state_nxt = RUN;
            end
         end else if (frame_sync && (r_slot != '0)) begin
            // Misplaced sync: realign onto slot 0 and abandon the partial frame.
            w_sync_err_nxt = 1'b1;
            w_wr_sel[0]    = 1'b1;
            w_slot_nxt     = SLOT_ONE;
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               if (r_slot == SEL_W'(k)) w_wr_sel[k] = 1'b1;
            end
            if (r_slot == SLOT_LAST) begin
               w_slot_nxt       = '0;
               w_frame_done_nxt = 1'b1;
            end else begin
               w_slot_nxt = r_slot + SLOT_ONE;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= HUNT;
         r_slot       <= '0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_slot       <= w_slot_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_sync_err   <= w_sync_err_nxt;
      end
   end

`ifdef TDM_FRAME_LATCH_EN
   logic [N_CH*DATA_W-1:0]  r_shadow;
   logic [N_CH*DATA_W-1:0]  w_shadow_nxt;

   always_comb begin
      w_shadow_nxt = r_shadow;
      for (int k = 0; k < N_CH; k++) begin
         if (w_wr_sel[k]) w_shadow_nxt[k*DATA_W +: DATA_W] = din;
      end
   end

   // Only a completed frame is copied out, together with its last sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow    <= '0;
         r_ch_data   <= '0;
         r_ch_strobe <= '0;
      end else begin
         r_shadow    <= w_shadow_nxt;
         r_ch_strobe <= w_frame_done_nxt ? {N_CH{1'b1}} : {N_CH{1'b0}};
         if (w_frame_done_nxt) r_ch_data <= w_shadow_nxt;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch_data   <= '0;
         r_ch_strobe <= '0;
      end else begin
         r_ch_strobe <= w_wr_sel;
         for (int k = 0; k < N_CH; k++) begin
            if (w_wr_sel[k]) r_ch_data[k*DATA_W +: DATA_W] <= din;
         end
      end
   end
`endif

   assign ch_data    = r_ch_data;
   assign ch_strobe  = r_ch_strobe;
   assign slot       = r_slot;
   assign locked     = (r_state == RUN);
   assign frame_done = r_frame_done;
   assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux: a vector table plus hand-written reset/latency sequences.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  din;
   logic        din_valid;
   logic        frame_sync;
   logic [15:0] ch_data;
   logic [3:0]  ch_strobe;
   logic [1:0]  slot;
   logic        locked;
   logic        frame_done;
   logic        sync_err;

   int n_pass  = 0;
   int n_total = 0;

   tdm_demux #(.N_CH(4), .DATA_W(4), .SEL_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .ch_data    (ch_data),
      .ch_strobe  (ch_strobe),
      .slot       (slot),
      .locked     (locked),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        vld;
      logic        fs;
      logic [3:0]  din;
      logic [15:0] ch;     // per-sample build
      logic [15:0] ch_fl;  // frame-latch build
      logic [3:0]  st;
      logic [3:0]  st_fl;
      logic [1:0]  slot;
      logic        locked;
      logic        fd;
      logic        se;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic r, input logic e, input logic v, input logic f, input logic [3:0] d);
      @(negedge clk);
      rst_n = r; en = e; din_valid = v; frame_sync = f; din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_ch;
      logic [3:0]  exp_st;
      int          cyc;
      bit          seen;

      rst_n = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
         check("rst_ch_data", ch_data, 16'h0);
         check("rst_locked", locked, 1'b0);
         check("rst_pulses", {ch_strobe, frame_done, sync_err, slot}, '0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      check("post_rst_all", {ch_data, ch_strobe, slot, locked, frame_done, sync_err}, '0);

      //                rst  en   vld  fs   din    ch        ch_fl     st     st_fl  slot   lk   fd   se
      // lock and first frame 1,2,4,8
      vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h1,16'h0001,16'h0000,4'h1,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h2,16'h0021,16'h0000,4'h2,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h4,16'h0421,16'h0000,4'h4,4'h0,2'd3,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h8,16'h8421,16'h8421,4'h8,4'hF,2'd0,1'b1,1'b1,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h0,16'h8421,16'h8421,4'h0,4'h0,2'd0,1'b1,1'b0,1'b0});
      // reset mid-stream, then hunt: sync without valid ignored, 3 unsynced samples discarded
      vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'hF,16'h0000,16'h0000,4'h0,4'h0,2'd0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'hA,16'h0000,16'h0000,4'h0,4'h0,2'd0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'hA,16'h0000,16'h0000,4'h0,4'h0,2'd0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'hB,16'h0000,16'h0000,4'h0,4'h0,2'd0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'hC,16'h0000,16'h0000,4'h0,4'h0,2'd0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h5,16'h0005,16'h0000,4'h1,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h6,16'h0065,16'h0000,4'h2,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h7,16'h0765,16'h0000,4'h4,4'h0,2'd3,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h9,16'h9765,16'h9765,4'h8,4'hF,2'd0,1'b1,1'b1,1'b0});
      // free-running frame without sync, then misplaced sync at slot 2
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h1,16'h9761,16'h9765,4'h1,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h2,16'h9721,16'h9765,4'h2,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h3,16'h9723,16'h9765,4'h1,4'h0,2'd1,1'b1,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h4,16'h9743,16'h9765,4'h2,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h5,16'h9543,16'h9765,4'h4,4'h0,2'd3,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h6,16'h6543,16'h6543,4'h8,4'hF,2'd0,1'b1,1'b1,1'b0});
      // gaps: en low, valid low (with stray sync), en low twice
      vecs.push_back('{1'b1,1'b1,1'b1,1'b1,4'h1,16'h6541,16'h6543,4'h1,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b1,1'b0,4'hF,16'h6541,16'h6543,4'h0,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b1,4'hF,16'h6541,16'h6543,4'h0,4'h0,2'd1,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h2,16'h6521,16'h6543,4'h2,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b1,1'b1,4'hE,16'h6521,16'h6543,4'h0,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,1'b1,1'b0,4'hD,16'h6521,16'h6543,4'h0,4'h0,2'd2,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h3,16'h6321,16'h6543,4'h4,4'h0,2'd3,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b1,1'b0,4'h4,16'h4321,16'h4321,4'h8,4'hF,2'd0,1'b1,1'b1,1'b0});
      vecs.push_back('{1'b1,1'b1,1'b0,1'b0,4'h0,16'h4321,16'h4321,4'h0,4'h0,2'd0,1'b1,1'b0,1'b0});

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].vld, vecs[i].fs, vecs[i].din);
`ifdef TDM_FRAME_LATCH_EN
         exp_ch = vecs[i].ch_fl;
         exp_st = vecs[i].st_fl;
`else
         exp_ch = vecs[i].ch;
         exp_st = vecs[i].st;
`endif
         check($sformatf("v%0d_ch_data", i), ch_data, exp_ch);
         check($sformatf("v%0d_ch_strobe", i), ch_strobe, exp_st);
         check($sformatf("v%0d_slot", i), slot, vecs[i].slot);
         check($sformatf("v%0d_locked", i), locked, vecs[i].locked);
         check($sformatf("v%0d_frame_done", i), frame_done, vecs[i].fd);
         check($sformatf("v%0d_sync_err", i), sync_err, vecs[i].se);
      end

      // Asynchronous reset between clock edges clears state immediately
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h7);
      check("async_pre_locked", locked, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_locked", locked, 1'b0);
      check("async_ch_data", ch_data, 16'h0);
      check("async_slot", slot, 2'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

      // Bounded wait for frame_done on a streamed frame 1,2,3,4
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 12) begin
         drive(1'b1, 1'b1, 1'b1, (cyc == 0), 4'(cyc + 1));
         if (frame_done) seen = 1'b1;
         else cyc++;
      end
      check("fd_seen", seen, 1'b1);
      check("fd_latency", cyc, 3);
      check("fd_ch_data", ch_data, 16'h4321);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      check("fd_single_cycle", {frame_done, ch_strobe, sync_err}, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
